// File: rtl/l1_dcache_responder_if.sv
// CPU data-memory port plus the line-wide port towards L2 / physical memory.
// "slave" is the cache side; "master" is the environment (CPU and lower memory).
interface l1_dcache_responder_if #(
  parameter int LINE_W = 128
);
  // CPU side
  logic                  mem_req;
  logic                  we_on_req;
  logic [15:0]           addr;
  logic [LINE_W/8-1:0]   byte_en;
  logic [LINE_W-1:0]     wdata;
  logic                  resp;
  logic [LINE_W-1:0]     rdata;

  // Lower-level memory side
  logic                  pmem_read;
  logic                  pmem_write;
  logic [15:0]           pmem_addr;
  logic [LINE_W-1:0]     pmem_wdata;
  logic [LINE_W-1:0]     pmem_rdata;
  logic                  pmem_resp;

  modport slave (
    input  mem_req, we_on_req, addr, byte_en, wdata, pmem_rdata, pmem_resp,
    output resp, rdata, pmem_read, pmem_write, pmem_addr, pmem_wdata
  );

  modport master (
    output mem_req, we_on_req, addr, byte_en, wdata, pmem_rdata, pmem_resp,
    input  resp, rdata, pmem_read, pmem_write, pmem_addr, pmem_wdata
  );
endinterface

// File: rtl/l1_dcache_responder.sv
// Direct-mapped, write-back, write-allocate L1 data cache.
// Hits answer in the request cycle; misses optionally write back the dirty
// victim line, then fill the whole line and let the held request hit.
module l1_dcache_responder #(
  parameter int IDX_W  = 3,
  parameter int LINE_W = 128
) (
  input  logic                    clk,
  input  logic                    reset_n,
  l1_dcache_responder_if.slave    bus
);

  localparam int NUM_SETS  = 2 ** IDX_W;
  localparam int OFF_W     = 4;
  localparam int TAG_W     = 16 - OFF_W - IDX_W;
  localparam int NUM_BYTES = LINE_W / 8;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    ALLOCATE
  } state_t;

  state_t state_reg;
  state_t state_next;

  // Line and tag storage are read combinationally so a hit can respond in
  // the same cycle; neither needs a reset because valid_reg gates them.
  logic [LINE_W-1:0] data_mem [NUM_SETS];
  logic [TAG_W-1:0]  tag_mem  [NUM_SETS];
  logic [NUM_SETS-1:0] valid_reg;
  logic [NUM_SETS-1:0] dirty_reg;

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  req_tag;
  logic [LINE_W-1:0] line_rd;
  logic [TAG_W-1:0]  tag_rd;
  logic              hit;
  logic              write_hit;
  logic              fill_done;
  logic              wb_done;
  logic [LINE_W-1:0] merged_line;
  logic [OFF_W-1:0]  unused_offset;

  assign idx           = bus.addr[OFF_W +: IDX_W];
  assign req_tag       = bus.addr[15 -: TAG_W];
  assign unused_offset = bus.addr[OFF_W-1:0];
  assign line_rd       = data_mem[idx];
  assign tag_rd        = tag_mem[idx];

  assign hit       = bus.mem_req & valid_reg[idx] & (tag_rd == req_tag);
  assign write_hit = (state_reg == IDLE) & hit & bus.we_on_req;
  assign fill_done = (state_reg == ALLOCATE) & bus.pmem_resp;
  assign wb_done   = (state_reg == WRITEBACK) & bus.pmem_resp;

  // Byte-lane merge of CPU write data into the currently stored line
  generate
    for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_byte_merge
      assign merged_line[8*gi +: 8] = bus.byte_en[gi] ? bus.wdata[8*gi +: 8]
                                                      : line_rd[8*gi +: 8];
    end
  endgenerate

  // Line/tag array update: fill installs the whole line, write hit merges bytes
  always_ff @(posedge clk) begin
    if (fill_done) begin
      data_mem[idx] <= bus.pmem_rdata;
      tag_mem[idx]  <= req_tag;
    end else if (write_hit) begin
      data_mem[idx] <= merged_line;
    end
  end

  // Valid/dirty bookkeeping; a write hit marks dirty even with no byte enabled
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_reg <= '0;
      dirty_reg <= '0;
    end else if (fill_done) begin
      valid_reg[idx] <= 1'b1;
      dirty_reg[idx] <= 1'b0;
    end else if (wb_done) begin
      dirty_reg[idx] <= 1'b0;
    end else if (write_hit) begin
      dirty_reg[idx] <= 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; pmem transactions always run to completion
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (bus.mem_req && !hit) begin
          state_next = (valid_reg[idx] && dirty_reg[idx]) ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        if (bus.pmem_resp) state_next = ALLOCATE;
      end
      ALLOCATE: begin
        if (bus.pmem_resp) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output decode; rdata and victim data always show the indexed line
  always_comb begin
    bus.resp       = 1'b0;
    bus.pmem_read  = 1'b0;
    bus.pmem_write = 1'b0;
    bus.pmem_addr  = {bus.addr[15:OFF_W], {OFF_W{1'b0}}};
    bus.pmem_wdata = line_rd;
    bus.rdata      = line_rd;
    case (state_reg)
      IDLE: begin
        bus.resp = hit;
      end
      WRITEBACK: begin
        bus.pmem_write = 1'b1;
        bus.pmem_addr  = {tag_rd, idx, {OFF_W{1'b0}}};
      end
      ALLOCATE: begin
        bus.pmem_read = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_l1_dcache_responder.sv
// Directed, table-driven bench for l1_dcache_responder with a small
// line-granular backing memory that answers fills and absorbs writebacks.
module tb_l1_dcache_responder;

  logic clk;
  logic reset_n;

  l1_dcache_responder_if #(.LINE_W(128)) bus ();

  l1_dcache_responder #(.IDX_W(3), .LINE_W(128)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Backing store: unwritten lines read as their own line address repeated
  logic [127:0] mem_store [logic [15:0]];

  function automatic logic [127:0] mem_line(input logic [15:0] a);
    if (mem_store.exists(a)) return mem_store[a];
    return {8{a}};
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  typedef struct {
    logic         we;
    logic [15:0]  addr;
    logic [15:0]  be;
    logic [127:0] wdata;
    logic [127:0] exp_rdata;
    int           exp_lat;
    int           exp_wb;
    logic [15:0]  exp_wb_addr;
    logic [127:0] exp_wb_data;
    int           exp_fill;
    logic [15:0]  exp_fill_addr;
  } vec_t;

  // Issue one request, service pmem with a fixed 3-cycle memory, wait for resp
  task automatic run_req(input logic we, input logic [15:0] a, input logic [15:0] be,
                         input logic [127:0] wd, output logic [127:0] rd, output int lat,
                         output int nwb, output logic [15:0] wba, output logic [127:0] wbd,
                         output int nfill, output logic [15:0] fa);
    int  cnt;
    bit  done;
    bit  both;
    cnt = 0; done = 0; both = 0; lat = 0; nwb = 0; nfill = 0;
    wba = '0; wbd = '0; fa = '0; rd = '0;
    @(posedge clk); #1;
    bus.we_on_req = we;
    bus.addr      = a;
    bus.byte_en   = be;
    bus.wdata     = wd;
    bus.mem_req   = 1'b1;
    for (int cyc = 0; cyc < 100 && !done; cyc++) begin
      @(negedge clk);
      if (bus.pmem_read && bus.pmem_write) both = 1;
      if (bus.pmem_resp) begin
        bus.pmem_resp = 1'b0;
      end else if (bus.pmem_read || bus.pmem_write) begin
        cnt++;
        if (cnt == 3) begin
          cnt = 0;
          bus.pmem_resp = 1'b1;
          if (bus.pmem_write) begin
            mem_store[bus.pmem_addr] = bus.pmem_wdata;
            nwb++;
            wba = bus.pmem_addr;
            wbd = bus.pmem_wdata;
          end else begin
            bus.pmem_rdata = mem_line(bus.pmem_addr);
            nfill++;
            fa = bus.pmem_addr;
          end
        end
      end
      if (bus.resp) begin
        done = 1;
        rd   = bus.rdata;
      end else begin
        lat++;
      end
    end
    chk("resp_within_budget", 128'(done), 128'(1));
    chk("pmem_rd_wr_exclusive", 128'(both), 128'(0));
    @(posedge clk); #1;
    bus.mem_req   = 1'b0;
    bus.we_on_req = 1'b0;
  endtask

  vec_t vecs[15];

  initial begin
    logic [127:0] rd;
    logic [127:0] wbd;
    logic [127:0] mod_line;
    logic [15:0]  wba;
    logic [15:0]  fa;
    int           lat;
    int           nwb;
    int           nfill;
    bit           seen;

    mod_line = {16'h1230, 16'h1230, 16'h1230, 16'h1230,
                16'h1230, 16'hBEEF, 16'h1230, 16'h1230};

    //            we    addr      be        wdata           exp_rdata          lat wb wb_addr   wb_data           fill fill_addr
    vecs[0]  = '{1'b0, 16'h1234, 16'h0000, 128'h0,         {8{16'h1230}},     4, 0, 16'h0000, 128'h0,           1, 16'h1230};
    vecs[1]  = '{1'b1, 16'h1234, 16'h0030, {8{16'hBEEF}},  {8{16'h1230}},     0, 0, 16'h0000, 128'h0,           0, 16'h0000};
    vecs[2]  = '{1'b0, 16'h1234, 16'h0000, 128'h0,         mod_line,          0, 0, 16'h0000, 128'h0,           0, 16'h0000};
    vecs[3]  = '{1'b0, 16'h1A34, 16'h0000, 128'h0,         {8{16'h1A30}},     8, 1, 16'h1230, mod_line,         1, 16'h1A30};
    vecs[4]  = '{1'b0, 16'h1234, 16'h0000, 128'h0,         mod_line,          4, 0, 16'h0000, 128'h0,           1, 16'h1230};
    vecs[5]  = '{1'b0, 16'h0010, 16'h0000, 128'h0,         {8{16'h0010}},     4, 0, 16'h0000, 128'h0,           1, 16'h0010};
    vecs[6]  = '{1'b0, 16'h0020, 16'h0000, 128'h0,         {8{16'h0020}},     4, 0, 16'h0000, 128'h0,           1, 16'h0020};
    vecs[7]  = '{1'b0, 16'h001C, 16'h0000, 128'h0,         {8{16'h0010}},     0, 0, 16'h0000, 128'h0,           0, 16'h0000};
    vecs[8]  = '{1'b0, 16'h0028, 16'h0000, 128'h0,         {8{16'h0020}},     0, 0, 16'h0000, 128'h0,           0, 16'h0000};
    vecs[9]  = '{1'b1, 16'h0010, 16'hFFFF, {8{16'hCAFE}},  {8{16'h0010}},     0, 0, 16'h0000, 128'h0,           0, 16'h0000};
    vecs[10] = '{1'b0, 16'h0010, 16'h0000, 128'h0,         {8{16'hCAFE}},     0, 0, 16'h0000, 128'h0,           0, 16'h0000};
    vecs[11] = '{1'b1, 16'h0050, 16'h0001, 128'h00AB,      {8{16'h0050}},     4, 0, 16'h0000, 128'h0,           1, 16'h0050};
    vecs[12] = '{1'b0, 16'h0054, 16'h0000, 128'h0,         {{7{16'h0050}}, 16'h00AB}, 0, 0, 16'h0000, 128'h0,   0, 16'h0000};
    vecs[13] = '{1'b1, 16'h0020, 16'h0000, {8{16'hFFFF}},  {8{16'h0020}},     0, 0, 16'h0000, 128'h0,           0, 16'h0000};
    vecs[14] = '{1'b0, 16'h0420, 16'h0000, 128'h0,         {8{16'h0420}},     8, 1, 16'h0020, {8{16'h0020}},    1, 16'h0420};

    reset_n        = 1'b0;
    bus.mem_req    = 1'b0;
    bus.we_on_req  = 1'b0;
    bus.addr       = '0;
    bus.byte_en    = '0;
    bus.wdata      = '0;
    bus.pmem_rdata = '0;
    bus.pmem_resp  = 1'b0;

    repeat (3) @(negedge clk);
    chk("reset_resp", 128'(bus.resp), 128'(0));
    chk("reset_pmem_read", 128'(bus.pmem_read), 128'(0));
    chk("reset_pmem_write", 128'(bus.pmem_write), 128'(0));
    reset_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      run_req(vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata,
              rd, lat, nwb, wba, wbd, nfill, fa);
      $display("txn %0d we=%0b addr=%h lat=%0d wb=%0d fill=%0d rdata=%h",
               i, vecs[i].we, vecs[i].addr, lat, nwb, nfill, rd);
      chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("v%0d_latency", i), 128'(lat), 128'(vecs[i].exp_lat));
      chk($sformatf("v%0d_writebacks", i), 128'(nwb), 128'(vecs[i].exp_wb));
      chk($sformatf("v%0d_fills", i), 128'(nfill), 128'(vecs[i].exp_fill));
      if (vecs[i].exp_wb != 0) begin
        chk($sformatf("v%0d_wb_addr", i), 128'(wba), 128'(vecs[i].exp_wb_addr));
        chk($sformatf("v%0d_wb_data", i), wbd, vecs[i].exp_wb_data);
      end
      if (vecs[i].exp_fill != 0) begin
        chk($sformatf("v%0d_fill_addr", i), 128'(fa), 128'(vecs[i].exp_fill_addr));
      end
    end

    // Stray pmem_resp while idle must not disturb anything
    @(negedge clk); bus.pmem_resp = 1'b1;
    @(negedge clk); bus.pmem_resp = 1'b0;
    run_req(1'b0, 16'h1234, 16'h0, 128'h0, rd, lat, nwb, wba, wbd, nfill, fa);
    $display("txn stray_resp addr=1234 lat=%0d rdata=%h", lat, rd);
    chk("stray_resp_latency", 128'(lat), 128'(0));
    chk("stray_resp_rdata", rd, mod_line);

    // mem_req dropped mid-fill: the fill completes and stays installed
    @(posedge clk); #1;
    bus.we_on_req = 1'b0;
    bus.addr      = 16'h0760;
    bus.mem_req   = 1'b1;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (bus.pmem_read) seen = 1;
    end
    chk("drop_wait_pmem_read", 128'(seen), 128'(1));
    bus.mem_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("drop_pmem_read_held", 128'(bus.pmem_read), 128'(1));
    bus.pmem_rdata = mem_line(bus.pmem_addr);
    bus.pmem_resp  = 1'b1;
    @(negedge clk);
    bus.pmem_resp  = 1'b0;
    chk("drop_pmem_read_released", 128'(bus.pmem_read), 128'(0));
    chk("drop_no_resp_without_req", 128'(bus.resp), 128'(0));
    run_req(1'b0, 16'h0760, 16'h0, 128'h0, rd, lat, nwb, wba, wbd, nfill, fa);
    $display("txn after_drop addr=0760 lat=%0d rdata=%h", lat, rd);
    chk("drop_refetch_latency", 128'(lat), 128'(0));
    chk("drop_refetch_rdata", rd, {8{16'h0760}});

    // Reset during ALLOCATE: pmem_read drops without a clock edge
    @(posedge clk); #1;
    bus.addr    = 16'h0300;
    bus.mem_req = 1'b1;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (bus.pmem_read) seen = 1;
    end
    chk("rst_wait_pmem_read", 128'(seen), 128'(1));
    #1 reset_n = 1'b0;
    #1;
    chk("rst_async_pmem_read", 128'(bus.pmem_read), 128'(0));
    bus.mem_req = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    run_req(1'b0, 16'h0300, 16'h0, 128'h0, rd, lat, nwb, wba, wbd, nfill, fa);
    $display("txn after_reset addr=0300 lat=%0d fill=%0d rdata=%h", lat, nfill, rd);
    chk("rst_refetch_latency", 128'(lat), 128'(4));
    chk("rst_refetch_fills", 128'(nfill), 128'(1));
    chk("rst_refetch_fill_addr", 128'(fa), 128'(16'h0300));
    chk("rst_refetch_rdata", rd, {8{16'h0300}});
    run_req(1'b0, 16'h1234, 16'h0, 128'h0, rd, lat, nwb, wba, wbd, nfill, fa);
    $display("txn after_reset addr=1234 lat=%0d fill=%0d rdata=%h", lat, nfill, rd);
    chk("rst_invalidated_latency", 128'(lat), 128'(4));
    chk("rst_invalidated_rdata", rd, mod_line);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
